dwconv_window_gen: RTL and testbench
====================================

# dwconv_window_gen

Raster-scan 3x3 window generator that feeds the depthwise-conv multiply-add cell. It accepts one 8-bit feature-map pixel per handshake and buffers two image rows in line buffers. For every pixel that completes a valid 3x3 neighbourhood, it emits the nine pixels packed in kernel order together with a one-cycle enable, which drives the MAC cell's `input_data` and `en` directly. Frame control (start/done) brackets one IMG_H x IMG_W channel plane.

## Interface
- `IMG_W`, default 28: pixels per row; must be ≥ 3.
- `IMG_H`, default 28: rows per frame; must be ≥ 3.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame; ignored unless the FSM is in IDLE.
- `pix_valid`  in  1  input pixel valid.
- `pix_data`  in  8  pixel byte; two's-complement, passed through unmodified.
- `pix_ready`  out  1  high in FILL/RUN only; a pixel is accepted when `pix_valid & pix_ready` is high at a rising edge.
- `win_data`  out  [0:71]  nine bytes; byte k occupies bits [8k:8k+7].
- `win_en`  out  1  one-cycle strobe marking `win_data` valid.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_done`  out  1  one-cycle pulse after the last pixel of the frame is accepted.

## Operation
- FSM states: IDLE, FILL, RUN, DONE.
  - IDLE → FILL on `start`.
  - FILL → RUN when the accepted pixel has row index 2 and column index 1, i.e. the next pixel completes the first window.
  - RUN → DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DONE → IDLE unconditionally after one cycle.
- Counters `row` and `col` track the position of the next pixel to accept.
  - `col` wraps from IMG_W-1 to 0 and increments `row`.
  - Both counters clear on `start`.
- Line buffers:
  - Two IMG_W-deep row delays are cascaded: row r-1 and row r-2.
  - A 3x3 shift register shifts left by one column per accepted pixel.
  - The new right column is (line2 out, line1 out, `pix_data`).
- Window validity: the accepted pixel (r,c) produces a window iff r ≥ 2 and c ≥ 2.
- Window byte k holds pixel (r-2+k/3, c-2+k%3), i.e. row-major, top-left first.
- Output count per frame is (IMG_H-2)*(IMG_W-2).
- `pix_valid` gaps stall everything; nothing shifts and no strobe is emitted.
- Line buffers are not cleared at `start`. The FILL gating alone guarantees that no stale data reaches a valid window.
- No output backpressure exists; the downstream MAC cell must accept every strobe.

## Timing
- Reset values: `pix_ready`=0, `win_en`=0, `win_data`=0, `busy`=0, `frame_done`=0, FSM=IDLE, counters=0.
- Latency: a pixel accepted at edge N drives `win_en` and `win_data` registered from edge N. The MAC captures them at edge N+1.
- `win_data` holds its value between strobes.
- `pix_ready` rises the cycle after `start`. It falls in the cycle after the final pixel is accepted.
- `frame_done` is high during the DONE cycle. `busy` drops one cycle later.
- A `start` pulse while busy is ignored, and the frame continues.
- `start` in the same cycle as DONE is ignored; it must be reissued once the FSM is in IDLE.
- Async reset mid-frame returns all outputs to their reset values immediately. Any partial window is discarded, and no `frame_done` is issued.

## Configuration
- `DWCONV_STRIDE2_EN` defined: stride 2.
  - A window is emitted only when r ≥ 2, c ≥ 2, (r-2) is even and (c-2) is even.
  - Output count per frame is ((IMG_H-3)/2+1)*((IMG_W-3)/2+1).
  - Line-buffer behaviour is unchanged.
- `DWCONV_STRIDE2_EN` undefined: stride 1, as described under Operation.

## Structure
- Shared package `dwconv_pkg` holds:
  - `KERNELS`=9;
  - `PIX_W`=8;
  - `WIN_W`=72;
  - FSM state encoding enum `dwconv_win_state_t`.
- One sub-module, `dwconv_line_buf`: a single-row IMG_W-deep byte delay that advances on an enable. It is instantiated twice.
- Row and column counters, the FSM and the 3x3 register array live in the top level.

## Test plan
- **Basic 4x4 frame, stride 1:** IMG_W=IMG_H=4, pixels 0..15 streamed continuously.
  - Exactly 4 strobes.
  - Windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
  - Each `win_en` arrives one cycle after the corresponding acceptance.
  - `frame_done` pulses once, after pixel 15.
- **Same frame with random `pix_valid` gaps:** identical windows in the same order, one strobe per completing pixel, no strobes during gaps.
- **Signed values:** pixels 0x80, 0xFF, 0x7F placed in the first window appear bit-exact at bytes 0, 4 and 8.
- **Back-to-back frames:** a second `start` after IDLE with pixels 100..115 yields windows containing only 100..115 (no stale data); a `start` pulse mid-frame is ignored.
- **Async reset mid-frame:** `rst_b` asserted low after pixel 7, then a new frame is run.
  - All outputs go to 0 immediately.
  - The new frame produces the full set of 4 correct windows.
- **`DWCONV_STRIDE2_EN`:** IMG_W=IMG_H=5, pixels 0..24.
  - Exactly 4 strobes, at pixels 12, 14, 22 and 24.
  - The first window is {0,1,2,5,6,7,10,11,12}.

Source files
------------

// File: rtl/dwconv_pkg.sv
// Shared constants and FSM encoding for the depthwise-conv 3x3 window generator.
package dwconv_pkg;
  localparam int KERNELS = 9;
  localparam int PIX_W   = 8;
  localparam int WIN_W   = 72;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } dwconv_win_state_t;
endpackage

// File: rtl/dwconv_line_buf.sv
// Single-row byte delay: dout is the byte written DEPTH enables ago.
// Contents are never cleared; only the pointer is reset.
module dwconv_line_buf
  import dwconv_pkg::*;
#(
  parameter int DEPTH = 28
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write: the slot about to be overwritten holds the oldest byte.
  assign dout = mem[ptr];

  // Storage write on each enabled step.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  // Circular pointer advance.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   ptr <= '0;
    else if (en)  ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end
endmodule

// File: rtl/dwconv_window_gen.sv
// Raster-scan 3x3 window generator feeding the depthwise-conv MAC cell.
// Optional build macro: DWCONV_STRIDE2_EN selects stride-2 window emission.
// Handshake: a pixel transfers on a rising edge where pix_valid & pix_ready;
// pix_ready depends only on the FSM state, never on pix_valid. There is no
// output backpressure: every win_en strobe must be consumed.
module dwconv_window_gen
  import dwconv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic [0:WIN_W-1]  win_data,
  output logic              win_en,
  output logic              busy,
  output logic              frame_done,
  output dwconv_win_state_t state_dbg
);
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  dwconv_win_state_t state, state_next;
  logic [15:0]       row, col;
  logic              accept, pos_ok, win_fire;
  logic [PIX_W-1:0]  l1_out, l2_out;
  logic [PIX_W-1:0]  win      [3][3];
  logic [PIX_W-1:0]  win_next [3][3];
  logic [0:WIN_W-1]  win_pack;

  assign accept     = pix_valid & pix_ready;
  assign pix_ready  = (state == FILL) || (state == RUN);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign state_dbg  = state;

  // Row r-1 delay, then row r-2 delay cascaded from it.
  dwconv_line_buf #(.DEPTH(IMG_W)) u_line1 (
    .clk(clk), .rst_b(rst_b), .en(accept), .din(pix_data), .dout(l1_out)
  );
  dwconv_line_buf #(.DEPTH(IMG_W)) u_line2 (
    .clk(clk), .rst_b(rst_b), .en(accept), .din(l1_out), .dout(l2_out)
  );

`ifdef DWCONV_STRIDE2_EN
  // (r-2) and (c-2) even is the same as r and c even.
  assign pos_ok = (row >= 16'd2) && (col >= 16'd2) && !row[0] && !col[0];
`else
  assign pos_ok = (row >= 16'd2) && (col >= 16'd2);
`endif

  // Windows only leave once FILL has primed the array with in-frame pixels.
  assign win_fire = accept && (state == RUN) && pos_ok;

  // Window after this acceptance: shift left, new right column from the buffers.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_next[i][0] = win[i][1];
      win_next[i][1] = win[i][2];
    end
    win_next[0][2] = l2_out;
    win_next[1][2] = l1_out;
    win_next[2][2] = pix_data;
  end

  // Row-major, top-left first byte packing.
  always_comb begin
    win_pack = '0;
    for (int k = 0; k < KERNELS; k++) begin
      win_pack[8*k +: 8] = win_next[k/3][k%3];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: if (accept && row == 16'd2 && col == 16'd1) state_next = RUN;
      RUN:  if (accept && row == LAST_ROW && col == LAST_COL) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position of the next pixel to accept.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // 3x3 shift array advances once per accepted pixel.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= win_next[i][j];
    end
  end

  // Registered strobe and window; data holds between strobes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      win_en   <= 1'b0;
      win_data <= '0;
    end else begin
      win_en <= win_fire;
      if (win_fire) win_data <= win_pack;
    end
  end
endmodule

// File: tb/tb_dwconv_window_gen.sv
// Bench for dwconv_window_gen; honours DWCONV_STRIDE2_EN for the stride-2 build.
module tb_dwconv_window_gen;
  import dwconv_pkg::*;

`ifdef DWCONV_STRIDE2_EN
  localparam int W = 5;
  localparam int H = 5;
  localparam int EXP_CNT = ((H - 3) / 2 + 1) * ((W - 3) / 2 + 1);
`else
  localparam int W = 4;
  localparam int H = 4;
  localparam int EXP_CNT = (H - 2) * (W - 2);
`endif
  localparam int NPIX = W * H;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              start;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_ready;
  logic [0:71]       win_data;
  logic              win_en;
  logic              busy;
  logic              frame_done;
  dwconv_win_state_t state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Frame contents and per-cycle record of one drive_frame run.
  logic [7:0]  frame_px[$];
  bit          rec_acc[$];
  int          rec_idx[$];
  logic        rec_en[$];
  logic        rec_done[$];
  logic [0:71] rec_data[$];
  int          done_cnt;
  bit          drive_timeout;
  logic        pr_done, busy_done, busy_after, done_after;

  dwconv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .win_data(win_data),
    .win_en(win_en), .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: does raster pixel n complete a window, and what is it.
  function automatic bit model_valid(input int n);
    int r, c;
    r = n / W;
    c = n % W;
`ifdef DWCONV_STRIDE2_EN
    return (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  function automatic logic [0:71] model_win(input int n);
    logic [0:71] w;
    int r, c;
    r = n / W;
    c = n % W;
    w = '0;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = frame_px[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
    return w;
  endfunction

  // Driver: start pulse, then stream frame_px[0..n_stop-1] with random gaps.
  task automatic drive_frame(input int gap_pct, input int n_stop, input bit mid_start);
    int  idx;
    int  guard;
    bit  acc;
    idx = 0;
    guard = 0;
    done_cnt = 0;
    rec_acc.delete(); rec_idx.delete(); rec_en.delete(); rec_done.delete(); rec_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (idx < n_stop && guard < 5000) begin
      guard++;
      pix_valid = ($urandom_range(0, 99) >= gap_pct);
      pix_data  = pix_valid ? frame_px[idx] : 8'($urandom);
      start     = mid_start && (idx == 5);
      acc       = pix_valid && pix_ready;
      @(posedge clk); #1;
      rec_acc.push_back(acc);
      rec_idx.push_back(idx);
      rec_en.push_back(win_en);
      rec_done.push_back(frame_done);
      rec_data.push_back(win_data);
      if (frame_done) done_cnt++;
      if (acc) idx++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    start = 1'b0;
    drive_timeout = (idx < n_stop);
    if (!drive_timeout && n_stop == NPIX) begin
      pr_done   = pix_ready;
      busy_done = busy;
      @(posedge clk); #1;
      busy_after = busy;
      done_after = frame_done;
      @(negedge clk);
    end
  endtask

  // Full-frame scenario check against the model.
  task automatic test_stream(input string name, input int gap_pct, input bit mid_start);
    bit exp_en;
    int n_obs;
    drive_frame(gap_pct, NPIX, mid_start);
    n_vec++;
    if (drive_timeout) begin
      n_err++;
      $display("FAIL %s timeout: got %0d cycles without finishing, expected %0d pixels", name, rec_acc.size(), NPIX);
    end
    n_obs = 0;
    foreach (rec_acc[i]) begin
      exp_en = rec_acc[i] && model_valid(rec_idx[i]);
      n_vec++;
      if (rec_en[i] !== exp_en) begin
        n_err++;
        $display("FAIL %s win_en cycle %0d pix %0d: got %b expected %b", name, i, rec_idx[i], rec_en[i], exp_en);
      end
      if (rec_en[i] === 1'b1) n_obs++;
      if (exp_en) begin
        n_vec++;
        if (rec_data[i] !== model_win(rec_idx[i])) begin
          n_err++;
          $display("FAIL %s win_data pix %0d: got %h expected %h", name, rec_idx[i], rec_data[i], model_win(rec_idx[i]));
        end
      end
    end
    n_vec++;
    if (n_obs != EXP_CNT) begin
      n_err++;
      $display("FAIL %s strobe_count: got %0d expected %0d", name, n_obs, EXP_CNT);
    end
    n_vec++;
    if (done_cnt != 1 || rec_done.size() == 0 || rec_done[rec_done.size() - 1] !== 1'b1) begin
      n_err++;
      $display("FAIL %s frame_done: got %0d pulses expected 1 right after last pixel", name, done_cnt);
    end
    n_vec++;
    if (pr_done !== 1'b0 || busy_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_cycle: got pix_ready=%b busy=%b expected 0/1", name, pr_done, busy_done);
    end
    n_vec++;
    if (busy_after !== 1'b0 || done_after !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got busy=%b frame_done=%b expected 0/0", name, busy_after, done_after);
    end
  endtask

  task automatic fill_random();
    frame_px.delete();
    for (int i = 0; i < NPIX; i++) frame_px.push_back(8'($urandom));
  endtask

  task automatic fill_ramp(input int base);
    frame_px.delete();
    for (int i = 0; i < NPIX; i++) frame_px.push_back(8'(base + i));
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
    repeat (2) @(negedge clk);
    n_vec++;
    if (pix_ready !== 1'b0 || win_en !== 1'b0 || win_data !== 72'h0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b en=%b data=%h busy=%b done=%b st=%0d expected all 0",
               pix_ready, win_en, win_data, busy, frame_done, state_dbg);
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int first;
`ifdef DWCONV_STRIDE2_EN
    int strobe_pix[$];
    int exp_pix[4] = '{12, 14, 22, 24};
    int exp_first[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
`else
    int exp_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`endif
    fill_ramp(0);
    test_stream("basic", 0, 1'b0);
    first = -1;
    foreach (rec_en[i]) if (rec_en[i] === 1'b1 && first < 0) first = i;
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (first < 0 || rec_data[first][8*k +: 8] !== 8'(exp_first[k])) begin
        n_err++;
        $display("FAIL basic first_win byte %0d: got %h expected %h", k,
                 (first < 0) ? 8'hxx : rec_data[first][8*k +: 8], 8'(exp_first[k]));
      end
    end
`ifdef DWCONV_STRIDE2_EN
    foreach (rec_en[i]) if (rec_en[i] === 1'b1) strobe_pix.push_back(rec_idx[i]);
    n_vec++;
    if (strobe_pix.size() != 4 || strobe_pix[0] != exp_pix[0] || strobe_pix[1] != exp_pix[1] ||
        strobe_pix[2] != exp_pix[2] || strobe_pix[3] != exp_pix[3]) begin
      n_err++;
      $display("FAIL stride2 strobe_pixels: got %p expected %p", strobe_pix, exp_pix);
    end
`endif
  endtask

  task automatic test_gaps();
    fill_ramp(0);
    test_stream("gaps", 40, 1'b0);
    fill_random();
    test_stream("gaps_random", 30, 1'b0);
  endtask

  task automatic test_signed();
    int first;
    logic [7:0] b0, b4, b8;
    fill_random();
    frame_px[0]         = 8'h80;
    frame_px[W + 1]     = 8'hFF;
    frame_px[2 * W + 2] = 8'h7F;
    test_stream("signed", 20, 1'b0);
    first = -1;
    foreach (rec_en[i]) if (rec_en[i] === 1'b1 && first < 0) first = i;
    b0 = (first < 0) ? 8'hxx : rec_data[first][0 +: 8];
    b4 = (first < 0) ? 8'hxx : rec_data[first][32 +: 8];
    b8 = (first < 0) ? 8'hxx : rec_data[first][64 +: 8];
    n_vec++;
    if (b0 !== 8'h80 || b4 !== 8'hFF || b8 !== 8'h7F) begin
      n_err++;
      $display("FAIL signed bytes0_4_8: got %h %h %h expected 80 ff 7f", b0, b4, b8);
    end
  endtask

  task automatic test_back_to_back();
    fill_ramp(100);
    test_stream("back_to_back", 0, 1'b1);
    fill_random();
    test_stream("back_to_back_rand", 25, 1'b1);
  endtask

  task automatic test_async_reset();
    fill_ramp(0);
    drive_frame(0, 8, 1'b0);
    #2 rst_b = 1'b0;
    #1;
    n_vec++;
    if (pix_ready !== 1'b0 || win_en !== 1'b0 || win_data !== 72'h0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL async_reset outputs: got rdy=%b en=%b data=%h busy=%b done=%b expected all 0",
               pix_ready, win_en, win_data, busy, frame_done);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset held: got busy=%b done=%b expected 0/0", busy, frame_done);
    end
    rst_b = 1'b1;
    @(negedge clk);
    fill_random();
    test_stream("after_reset", 10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_signed();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
